adc_spi_responder: RTL and testbench

SPI responder that emulates the board's 8-channel, 12-bit ADC serial protocol so the `adc_spi_read` master can be exercised in loopback without the physical ADC. The block sits in the fabric next to the SOPC system. It samples the master's SCLK, CS_n and SADDR lines, and returns 16-bit frames built from parallel channel values supplied by test logic. It uses a single clock and oversamples the SPI lines; it does not clock on SCLK.

---
 rtl/adc_spi_responder.sv | 119 +++++++++++
 tb/tb_adc_spi_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_responder.sv
// rtl/adc_spi_responder.sv - oversampled SPI responder emulating an 8-channel 12-bit serial ADC
module adc_spi_responder #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 12
) (
  input  logic                     i_clk_50,
  input  logic                     i_reset,
  input  logic [NUM_CH*DATA_W-1:0] i_ch_data,
  input  logic                     i_spi_sclk,
  input  logic                     i_spi_cs_n,
  input  logic                     i_spi_din,
  output logic                     o_spi_dout,
  output logic                     o_spi_dout_oe,
  output logic [2:0]               o_cur_channel,
  output logic                     o_frame_done
);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t            r_state;
  logic [2:0]        r_sclk_sync;
  logic [2:0]        r_cs_sync;
  logic [1:0]        r_din_sync;
  logic [2:0]        r_addr;
  logic [2:0]        r_cap;
  logic [3:0]        r_bit_cnt;
  logic [15:0]       r_shift;
  logic              r_reload;
  logic              r_rose;
  logic              r_done;

  logic              w_sclk_rise;
  logic              w_sclk_fall;
  logic              w_cs_rise;
  logic              w_cs_fall;
  logic [DATA_W-1:0] w_sel_data;
  logic [15:0]       w_frame;

  // Sync chains keep sampling through reset so a reset never fakes an edge.
  always_ff @(posedge i_clk_50) begin
    r_sclk_sync <= {r_sclk_sync[1:0], i_spi_sclk};
    r_cs_sync   <= {r_cs_sync[1:0], i_spi_cs_n};
    r_din_sync  <= {r_din_sync[0], i_spi_din};
  end

  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
  assign w_cs_rise   = r_cs_sync[1] & ~r_cs_sync[2];
  assign w_cs_fall   = ~r_cs_sync[1] & r_cs_sync[2];

  assign w_sel_data  = i_ch_data[int'(r_addr)*DATA_W +: DATA_W];
  assign w_frame     = {{(16-DATA_W){1'b0}}, w_sel_data};

  always_ff @(posedge i_clk_50) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_addr        <= 3'd0;
      r_cap         <= 3'd0;
      r_bit_cnt     <= 4'd0;
      r_shift       <= 16'd0;
      r_reload      <= 1'b0;
      r_rose        <= 1'b0;
      r_done        <= 1'b0;
      o_spi_dout    <= 1'b0;
      o_spi_dout_oe <= 1'b0;
      o_cur_channel <= 3'd0;
      o_frame_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cs_fall) begin
            r_state   <= S_ACTIVE;
            r_bit_cnt <= 4'd0;
            r_reload  <= 1'b0;
            r_rose    <= 1'b0;
            r_shift   <= w_frame;
          end
        end
        S_ACTIVE: begin
          // A chip-select edge takes priority over any SCLK edge in the same cycle.
          if (w_cs_rise) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 4'd0;
            r_reload  <= 1'b0;
            r_rose    <= 1'b0;
          end else if (w_sclk_rise) begin
            r_rose <= 1'b1;
            if (r_bit_cnt >= 4'd2 && r_bit_cnt <= 4'd4) begin
              r_cap <= {r_cap[1:0], r_din_sync[1]};
            end
            if (r_bit_cnt == 4'd15) begin
              r_addr    <= r_cap;
              r_done    <= 1'b1;
              r_bit_cnt <= 4'd0;
              r_reload  <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end else if (w_sclk_fall && r_rose) begin
            if (r_reload) begin
              r_shift  <= w_frame;
              r_reload <= 1'b0;
            end else begin
              r_shift <= {r_shift[14:0], 1'b0};
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Output stage adds one cycle after the state update.
      o_spi_dout_oe <= (r_state == S_ACTIVE);
      o_spi_dout    <= (r_state == S_ACTIVE) && r_shift[15];
      o_cur_channel <= r_addr;
      o_frame_done  <= r_done;
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// tb/tb_adc_spi_responder.sv - directed self-checking bench for adc_spi_responder
module tb_adc_spi_responder;
  localparam int NUM_CH = 8;
  localparam int DATA_W = 12;
  localparam int HALF   = 12;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic                     sclk;
  logic                     cs_n;
  logic                     din;
  logic                     spi_dout;
  logic                     spi_dout_oe;
  logic [2:0]               cur_channel;
  logic                     frame_done;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_done  = 0;
  int          done_pos;
  logic [15:0] rx_word;

  always #10 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) n_done++;

  adc_spi_responder #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .i_clk_50      (clk),
    .i_reset       (reset),
    .i_ch_data     (ch_data),
    .i_spi_sclk    (sclk),
    .i_spi_cs_n    (cs_n),
    .i_spi_din     (din),
    .o_spi_dout    (spi_dout),
    .o_spi_dout_oe (spi_dout_oe),
    .o_cur_channel (cur_channel),
    .o_frame_done  (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs_zero(input string tag);
    check(tag, 32'({spi_dout, spi_dout_oe, cur_channel, frame_done}), 32'd0);
  endtask

  task automatic set_ch(input int ch, input logic [11:0] v);
    ch_data[ch*DATA_W +: DATA_W] = v;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_select();
    cs_n = 1'b0;
    wait_clk(6);
  endtask

  task automatic cs_release();
    cs_n = 1'b1;
    wait_clk(6);
  endtask

  // Master model: SCLK idles high, DIN driven on falling edges, DOUT sampled just before rising.
  task automatic spi_clocks(input logic [2:0] addr, input int first, input int last, input bit collide);
    for (int i = first; i <= last; i++) begin
      sclk = 1'b0;
      din  = (i >= 2 && i <= 4) ? addr[4-i] : 1'b1;
      wait_clk(HALF);
      rx_word = {rx_word[14:0], spi_dout};
      sclk = 1'b1;
      if (collide && i == last) cs_n = 1'b1;
      for (int k = 1; k <= HALF; k++) begin
        @(negedge clk);
        if (frame_done === 1'b1 && done_pos == 0) done_pos = k;
      end
    end
  endtask

  task automatic full_frame(input logic [2:0] addr);
    rx_word  = 16'd0;
    done_pos = 0;
    spi_clocks(addr, 0, 15, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ch_data = '0;
    set_ch(0, 12'hABC); set_ch(1, 12'h111); set_ch(2, 12'h123); set_ch(3, 12'h333);
    set_ch(4, 12'h444); set_ch(5, 12'h5A5); set_ch(6, 12'h666); set_ch(7, 12'h777);

    // Reset with SPI lines toggling
    reset = 1'b1; cs_n = 1'b0; sclk = 1'b0; din = 1'b1;
    @(negedge clk); check_outs_zero("rst_c1");
    cs_n = 1'b1; sclk = 1'b1; din = 1'b0;
    @(negedge clk); check_outs_zero("rst_c2");
    sclk = 1'b0; din = 1'b1;
    @(negedge clk); check_outs_zero("rst_c3");
    reset = 1'b0; sclk = 1'b1; cs_n = 1'b1; din = 1'b0;
    @(negedge clk); check_outs_zero("rst_release");
    wait_clk(6);

    // Single frame, address 5
    cs_select();
    full_frame(3'd5);
    check("single_rx", 32'(rx_word), 32'h0ABC);
    check("single_done_lat", 32'(done_pos), 32'd4);
    check("single_cur", 32'(cur_channel), 32'd5);
    check("single_ndone", 32'(n_done), 32'd1);

    // Two back-to-back frames
    full_frame(3'd2);
    check("b2b1_rx", 32'(rx_word), 32'h05A5);
    check("b2b1_cur", 32'(cur_channel), 32'd2);
    full_frame(3'd0);
    check("b2b2_rx", 32'(rx_word), 32'h0123);
    check("b2b2_cur", 32'(cur_channel), 32'd0);
    check("b2b_ndone", 32'(n_done), 32'd3);
    cs_release();
    check("b2b_oe_off", 32'(spi_dout_oe), 32'd0);

    // Abort after 8 SCLK with address 7
    cs_select();
    rx_word = 16'd0; done_pos = 0;
    spi_clocks(3'd7, 0, 7, 1'b0);
    cs_n = 1'b1;
    wait_clk(3);
    check("abort_oe_hold", 32'(spi_dout_oe), 32'd1);
    wait_clk(1);
    check("abort_oe_off", 32'({spi_dout_oe, spi_dout}), 32'd0);
    wait_clk(6);
    check("abort_ndone", 32'(n_done), 32'd3);
    check("abort_cur", 32'(cur_channel), 32'd0);
    cs_select();
    full_frame(3'd4);
    check("abort_next_rx", 32'(rx_word), 32'h0ABC);
    check("abort_next_cur", 32'(cur_channel), 32'd4);
    cs_release();

    // Channel data changed mid-frame must not disturb the latched word
    cs_select();
    rx_word = 16'd0; done_pos = 0;
    spi_clocks(3'd6, 0, 7, 1'b0);
    set_ch(4, 12'hFFF);
    spi_clocks(3'd6, 8, 15, 1'b0);
    check("latch_rx", 32'(rx_word), 32'h0444);
    check("latch_cur", 32'(cur_channel), 32'd6);
    cs_release();

    // CS rises together with the 16th SCLK rising edge
    cs_select();
    rx_word = 16'd0; done_pos = 0;
    spi_clocks(3'd1, 0, 15, 1'b1);
    wait_clk(6);
    check("collide_ndone", 32'(n_done), 32'd5);
    check("collide_cur", 32'(cur_channel), 32'd6);
    cs_select();
    full_frame(3'd4);
    check("collide_next_rx", 32'(rx_word), 32'h0666);
    check("collide_next_cur", 32'(cur_channel), 32'd4);
    cs_release();

    // Reset after 10 SCLK with committed channel 4
    cs_select();
    rx_word = 16'd0; done_pos = 0;
    spi_clocks(3'd7, 0, 9, 1'b0);
    reset = 1'b1; cs_n = 1'b1; sclk = 1'b1;
    @(negedge clk); check_outs_zero("rstmid_c1");
    @(negedge clk); check_outs_zero("rstmid_c2");
    @(negedge clk); check_outs_zero("rstmid_c3");
    reset = 1'b0;
    @(negedge clk); check_outs_zero("rstmid_release");
    wait_clk(6);
    check("rstmid_ndone", 32'(n_done), 32'd6);
    cs_select();
    full_frame(3'd2);
    check("rstmid_next_rx", 32'(rx_word), 32'h0ABC);
    check("rstmid_next_cur", 32'(cur_channel), 32'd2);
    check("final_ndone", 32'(n_done), 32'd7);
    cs_release();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
